imsic_csr_arbiter: RTL



---
 rtl/imsic_csr_arbiter.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/imsic_csr_arbiter.sv
// imsic_csr_arbiter
// -----------------
// Shares the per-IMSIC CSR ports of imsic_top between NR_MASTERS requesters
// (harts, debug module). One transaction is in flight at a time:
//   IDLE    : round-robin grant, o_req_ready asserted combinationally
//   DRIVE   : latched request driven onto the target IMSIC, we/claim pulse
//   CAPTURE : address still driven, read data / exception sampled
//   RESP    : response held on the shared rsp bus until the master accepts
// A target index >= NR_IMSICS skips DRIVE/CAPTURE and answers with an error.
//
// Ports
//   i_clk, i_rst            clock, asynchronous active-high reset
//   i_req_*, o_req_ready    per-master request channel (packed per master)
//   o_rsp_valid, i_rsp_ready per-master response handshake
//   o_rsp_rdata, o_rsp_error shared response payload, qualified by o_rsp_valid
//   o_priv_lvl .. o_imsic_claim   per-IMSIC CSR port drive toward imsic_top
//   i_imsic_data, i_imsic_exception  per-IMSIC read data / illegal-access flag
module imsic_csr_arbiter #(
    parameter int NR_MASTERS            = 4,
    parameter int NR_IMSICS             = 4,
    parameter int NR_VS_FILES_PER_IMSIC = 1,
    parameter int VS_INTP_FILE_LEN      = $clog2(NR_VS_FILES_PER_IMSIC),
    parameter int IDX_W                 = (NR_IMSICS > 1) ? $clog2(NR_IMSICS) : 1
) (
    input  logic                                        i_clk,
    input  logic                                        i_rst,
    input  logic [NR_MASTERS-1:0]                       i_req_valid,
    output logic [NR_MASTERS-1:0]                       o_req_ready,
    input  logic [NR_MASTERS*IDX_W-1:0]                 i_req_imsic,
    input  logic [NR_MASTERS*2-1:0]                     i_req_priv_lvl,
    input  logic [NR_MASTERS*(VS_INTP_FILE_LEN+1)-1:0]  i_req_vgein,
    input  logic [NR_MASTERS*32-1:0]                    i_req_addr,
    input  logic [NR_MASTERS*32-1:0]                    i_req_wdata,
    input  logic [NR_MASTERS-1:0]                       i_req_we,
    input  logic [NR_MASTERS-1:0]                       i_req_claim,
    output logic [NR_MASTERS-1:0]                       o_rsp_valid,
    input  logic [NR_MASTERS-1:0]                       i_rsp_ready,
    output logic [31:0]                                 o_rsp_rdata,
    output logic                                        o_rsp_error,
    output logic [NR_IMSICS*2-1:0]                      o_priv_lvl,
    output logic [NR_IMSICS*(VS_INTP_FILE_LEN+1)-1:0]   o_vgein,
    output logic [NR_IMSICS*32-1:0]                     o_imsic_addr,
    output logic [NR_IMSICS*32-1:0]                     o_imsic_data,
    output logic [NR_IMSICS-1:0]                        o_imsic_we,
    output logic [NR_IMSICS-1:0]                        o_imsic_claim,
    input  logic [NR_IMSICS*32-1:0]                     i_imsic_data,
    input  logic [NR_IMSICS-1:0]                        i_imsic_exception
);

    localparam int VG_W  = VS_INTP_FILE_LEN + 1;
    localparam int MID_W = (NR_MASTERS > 1) ? $clog2(NR_MASTERS) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DRIVE   = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } state_e;

    state_e              state_r;
    logic [MID_W-1:0]    rr_r;
    logic [MID_W-1:0]    mst_r;
    logic [IDX_W-1:0]    tgt_r;

    logic [MID_W-1:0]    cand_s;
    logic [MID_W-1:0]    grant_id_s;
    logic                grant_vld_s;
    logic [IDX_W-1:0]    grant_tgt_s;
    logic                grant_oor_s;
    logic [NR_IMSICS-1:0] grant_oh_s;
    logic [NR_IMSICS-1:0] tgt_oh_s;
    logic                rsp_hs_s;

    // Round-robin search: first valid master at or after the rr pointer.
    always_comb begin
        grant_vld_s = 1'b0;
        grant_id_s  = '0;
        cand_s      = '0;
        for (int i = 0; i < NR_MASTERS; i++) begin
            cand_s = MID_W'((int'(rr_r) + i) % NR_MASTERS);
            if (!grant_vld_s && i_req_valid[cand_s]) begin
                grant_vld_s = 1'b1;
                grant_id_s  = cand_s;
            end else begin
                grant_vld_s = grant_vld_s;
            end
        end
    end

    assign grant_tgt_s = i_req_imsic[grant_id_s*IDX_W +: IDX_W];
    // Index width may exceed what NR_IMSICS needs, so range-check explicitly.
    assign grant_oor_s = (int'(grant_tgt_s) >= NR_IMSICS);
    assign grant_oh_s  = NR_IMSICS'(1'b1) << grant_tgt_s;
    assign tgt_oh_s    = NR_IMSICS'(1'b1) << tgt_r;
    // o_rsp_valid is one-hot on the latched master, so a plain AND finds the handshake.
    assign rsp_hs_s    = |(o_rsp_valid & i_rsp_ready);

    // Grant is visible the same cycle it is computed; masked in reset and while busy.
    always_comb begin
        o_req_ready = '0;
        if (!i_rst && (state_r == IDLE) && grant_vld_s) begin
            o_req_ready = NR_MASTERS'(1'b1) << grant_id_s;
        end else begin
            o_req_ready = '0;
        end
    end

    // Transaction FSM; all downstream and response outputs are registered here.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_r       <= IDLE;
            rr_r          <= '0;
            mst_r         <= '0;
            tgt_r         <= '0;
            o_rsp_valid   <= '0;
            o_rsp_rdata   <= 32'h0000_0000;
            o_rsp_error   <= 1'b0;
            o_priv_lvl    <= '0;
            o_vgein       <= '0;
            o_imsic_addr  <= '0;
            o_imsic_data  <= '0;
            o_imsic_we    <= '0;
            o_imsic_claim <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (grant_vld_s) begin
                        mst_r <= grant_id_s;
                        tgt_r <= grant_tgt_s;
                        if (grant_oor_s) begin
                            // Unreachable target: answer directly, leave imsic_top untouched.
                            state_r     <= RESP;
                            o_rsp_valid <= NR_MASTERS'(1'b1) << grant_id_s;
                            o_rsp_rdata <= 32'h0000_0000;
                            o_rsp_error <= 1'b1;
                        end else begin
                            // The downstream registers double as the request latch.
                            state_r <= DRIVE;
                            o_priv_lvl   <= '0;
                            o_vgein      <= '0;
                            o_imsic_addr <= '0;
                            o_imsic_data <= '0;
                            o_priv_lvl[grant_tgt_s*2 +: 2] <=
                                i_req_priv_lvl[grant_id_s*2 +: 2];
                            o_vgein[grant_tgt_s*VG_W +: VG_W] <=
                                i_req_vgein[grant_id_s*VG_W +: VG_W];
                            o_imsic_addr[grant_tgt_s*32 +: 32] <=
                                i_req_addr[grant_id_s*32 +: 32];
                            o_imsic_data[grant_tgt_s*32 +: 32] <=
                                i_req_wdata[grant_id_s*32 +: 32];
                            o_imsic_we    <= i_req_we[grant_id_s]    ? grant_oh_s : '0;
                            o_imsic_claim <= i_req_claim[grant_id_s] ? grant_oh_s : '0;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                DRIVE: begin
                    // we/claim are single-cycle pulses.
                    state_r       <= CAPTURE;
                    o_imsic_we    <= '0;
                    o_imsic_claim <= '0;
                end
                CAPTURE: begin
                    // Read data is captured for writes too (old value).
                    state_r      <= RESP;
                    o_rsp_rdata  <= i_imsic_data[tgt_r*32 +: 32];
                    o_rsp_error  <= |(i_imsic_exception & tgt_oh_s);
                    o_rsp_valid  <= NR_MASTERS'(1'b1) << mst_r;
                    o_priv_lvl   <= '0;
                    o_vgein      <= '0;
                    o_imsic_addr <= '0;
                    o_imsic_data <= '0;
                end
                RESP: begin
                    if (rsp_hs_s) begin
                        state_r     <= IDLE;
                        o_rsp_valid <= '0;
                        o_rsp_rdata <= 32'h0000_0000;
                        o_rsp_error <= 1'b0;
                        if (int'(mst_r) == NR_MASTERS - 1) begin
                            rr_r <= '0;
                        end else begin
                            rr_r <= mst_r + 1'b1;
                        end
                    end else begin
                        state_r <= RESP;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule
